// File: rtl/fifo_uart_tx.sv
// Pops one byte from the upstream FIFO when idle and sends it as a UART 8N1/8N2 frame, LSB first.
// Start bit begins 3 cycles after the pop decision; the FIFO is only popped from IDLE, so it never underflows.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data_i,
  input  logic       empty_i,
  output logic       rd_en,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bit_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (!empty_i) state_d = S_RD;
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shift_d = data_i;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        // idx_q counts stop bits here so two stop bits reuse the per-bit counter
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they can be registered with no extra latency.
    rd_d   = (state_d == S_RD);
    busy_d = (state_d != S_IDLE);
    tx_d   = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_en  = rd_q;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
